// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one req/ack bus transaction per memory
// instruction, byte/halfword lane formatting, misalignment and timeout
// detection, and write-back field generation for MEM/WB.
module mem_access_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      load_flag,
    input  logic [2:0]      store_flag,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] store_data,
    input  logic            rd_en_in,
    input  logic [4:0]      rd_addr_in,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack,
    output logic            stall_req,
    output logic [XLEN-1:0] rd_out,
    output logic            rd_en_out,
    output logic [4:0]      rd_addr_out,
    output logic            misalign,
    output logic            bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t          state_q;
    logic            req_q, we_q, sext_q, load_q, rd_en_q, abort_q, err_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]      be_q;
    size_t           size_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_addr_q;
    logic [TO_W-1:0] cnt_q;

    logic            mem_op, is_load, mis_d, sext_d;
    size_t           size_d;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d, ld_fmt;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Decode the presented op: load wins over store, lowest flag bit wins.
    always_comb begin
        mem_op  = (|load_flag) | (|store_flag);
        is_load = |load_flag;
        size_d  = SZ_W;
        sext_d  = 1'b0;
        if (is_load) begin
            if (load_flag[0])      begin size_d = SZ_B; sext_d = 1'b1; end
            else if (load_flag[1]) begin size_d = SZ_H; sext_d = 1'b1; end
            else if (load_flag[2]) size_d = SZ_W;
            else if (load_flag[3]) size_d = SZ_B;
            else                   size_d = SZ_H;
        end else begin
            if (store_flag[0])      size_d = SZ_B;
            else if (store_flag[1]) size_d = SZ_H;
            else                    size_d = SZ_W;
        end
        mis_d = ((size_d == SZ_H) && addr_in[0]) ||
                ((size_d == SZ_W) && (addr_in[1:0] != 2'b00));
        case (size_d)
            SZ_B:    be_d = 4'b0001 << addr_in[1:0];
            SZ_H:    be_d = addr_in[1] ? 4'b1100 : 4'b0011;
            default: be_d = 4'b1111;
        endcase
        if (is_load)            wdata_d = '0;
        else if (size_d == SZ_B) wdata_d = {(XLEN/8){store_data[7:0]}};
        else if (size_d == SZ_H) wdata_d = {(XLEN/16){store_data[15:0]}};
        else                     wdata_d = store_data;
    end

    // Extract and extend the addressed lane of the returning read data.
    always_comb begin
        byte_sel = bus_rdata[{off_q, 3'b000} +: 8];
        half_sel = bus_rdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    ld_fmt = {{(XLEN-8){sext_q & byte_sel[7]}}, byte_sel};
            SZ_H:    ld_fmt = {{(XLEN-16){sext_q & half_sel[15]}}, half_sel};
            default: ld_fmt = bus_rdata;
        endcase
    end

    // Transaction FSM: latch op in IDLE, hold bus in REQ until ack or timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_W;
            sext_q    <= 1'b0;
            off_q     <= '0;
            load_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_op && !mis_d) begin
                        state_q   <= S_REQ;
                        req_q     <= 1'b1;
                        we_q      <= !is_load;
                        addr_q    <= {addr_in[XLEN-1:2], 2'b00};
                        be_q      <= be_d;
                        wdata_q   <= wdata_d;
                        size_q    <= size_d;
                        sext_q    <= sext_d;
                        off_q     <= addr_in[1:0];
                        load_q    <= is_load;
                        rd_en_q   <= rd_en_in;
                        rd_addr_q <= rd_addr_in;
                        cnt_q     <= '0;
                        abort_q   <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        rdata_q <= ld_fmt;
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write-back fields: pass-through for non-memory ops, load result in DONE.
    always_comb begin
        rd_out      = addr_in;
        rd_addr_out = rd_addr_in;
        rd_en_out   = 1'b0;
        case (state_q)
            S_IDLE: if (!mem_op) rd_en_out = rd_en_in;
            S_DONE: begin
                rd_out      = rdata_q;
                rd_addr_out = rd_addr_q;
                rd_en_out   = load_q & rd_en_q & !abort_q;
            end
            default: ;
        endcase
    end

    assign stall_req = ((state_q == S_IDLE) && mem_op && !mis_d) || (state_q == S_REQ);
    assign misalign  = (state_q == S_IDLE) && mem_op && mis_d;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized
// ops scored against a behavioural model of the load/store rules.
module tb_mem_access_ctrl;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  load_flag;
    logic [2:0]  store_flag;
    logic [31:0] addr_in, store_data, bus_rdata, bus_addr, bus_wdata, rd_out;
    logic        rd_en_in, bus_req, bus_we, bus_ack, stall_req, rd_en_out, misalign, bus_err;
    logic [4:0]  rd_addr_in, rd_addr_out;
    logic [3:0]  bus_be;

    mem_access_ctrl #(.XLEN(32), .TIMEOUT(TO), .TO_W(3)) dut (
        .clk(clk), .rst(rst), .load_flag(load_flag), .store_flag(store_flag),
        .addr_in(addr_in), .store_data(store_data), .rd_en_in(rd_en_in),
        .rd_addr_in(rd_addr_in), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall_req(stall_req),
        .rd_out(rd_out), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Observations of one instruction, gathered by do_access.
    int          obs_req, obs_stall, obs_mis, obs_err, obs_rden;
    logic        obs_we, obs_stable, obs_done, wb_en;
    logic [31:0] obs_addr, obs_wdata, wb_out;
    logic [3:0]  obs_be;
    logic [4:0]  wb_addr;

    // Model expectations for one instruction.
    int          exp_req, exp_stall, exp_mis, exp_err, exp_rden;
    logic        exp_we, exp_access, exp_store, exp_wb_en;
    logic [31:0] exp_addr, exp_wdata, exp_wb_out;
    logic [3:0]  exp_be;

    // 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
    function automatic int classify(input logic [4:0] lf, input logic [2:0] sf);
        if (lf != 5'd0) begin
            for (int i = 0; i < 5; i++) if (lf[i]) return i + 1;
        end
        for (int i = 0; i < 3; i++) if (sf[i]) return i + 6;
        return 0;
    endfunction

    function automatic int size_of(input int kind);
        case (kind)
            1, 4, 6: return 1;
            2, 5, 7: return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model(input logic [4:0] lf, input logic [2:0] sf, input logic [31:0] a,
                         input logic [31:0] sd, input logic re, input logic [31:0] rdata,
                         input int wait_n);
        int kind, sz, off;
        bit is_ld, ack_ok;
        longint unsigned v, m, r;
        kind  = classify(lf, sf);
        sz    = size_of(kind);
        off   = int'(a % 4);
        is_ld = (kind >= 1 && kind <= 5);
        exp_access = 0; exp_store = 0; exp_mis = 0; exp_err = 0;
        exp_req = 0; exp_stall = 0; exp_wb_en = 0; exp_wb_out = a;
        exp_we = !is_ld;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_be = 4'(((1 << sz) - 1) << off);
        exp_wdata = (sz == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                    (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        if (kind == 0) begin
            exp_wb_en = re;
        end else if ((off % sz) != 0) begin
            exp_mis = 1;
        end else begin
            exp_access = 1;
            exp_store  = !is_ld;
            ack_ok     = (wait_n >= 0) && (wait_n < int'(TO));
            exp_req    = ack_ok ? wait_n + 1 : int'(TO);
            exp_stall  = exp_req + 1;
            exp_err    = ack_ok ? 0 : 1;
            exp_wb_en  = is_ld && re && ack_ok;
            r = longint'(rdata);
            m = (64'd1 << (8 * sz)) - 1;
            v = (r >> (8 * off)) & m;
            if ((kind == 1 || kind == 2) && v > m / 2) v = v + 64'h1_0000_0000 - (m + 1);
            exp_wb_out = v[31:0];
        end
        exp_rden = exp_wb_en ? 1 : 0;
    endtask

    // Present one instruction and follow it until the pipeline is released.
    task automatic do_access(input logic [4:0] lf, input logic [2:0] sf, input logic [31:0] a,
                             input logic [31:0] sd, input logic re, input logic [4:0] ra,
                             input logic [31:0] rdata, input int wait_n);
        int k;
        bit first;
        @(posedge clk); #1;
        load_flag = lf; store_flag = sf; addr_in = a; store_data = sd;
        rd_en_in = re; rd_addr_in = ra;
        #1;
        obs_req = 0; obs_stall = 0; obs_mis = 0; obs_err = 0; obs_rden = 0;
        obs_stable = 1'b1; obs_done = 1'b0; obs_we = 1'b0; obs_addr = '0;
        obs_be = '0; obs_wdata = '0; k = 0; first = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (stall_req) obs_stall++;
            if (misalign)  obs_mis++;
            if (bus_err)   obs_err++;
            if (rd_en_out) obs_rden++;
            if (bus_req) begin
                obs_req++;
                if (first) begin
                    obs_we = bus_we; obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata;
                    first = 1'b0;
                end else if ({bus_we, bus_addr, bus_be, bus_wdata} !== {obs_we, obs_addr, obs_be, obs_wdata}) begin
                    obs_stable = 1'b0;
                end
                bus_ack   = (k == wait_n);
                bus_rdata = bus_ack ? rdata : $urandom;
                k++;
            end else begin
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
            if (!stall_req) begin
                wb_out = rd_out; wb_addr = rd_addr_out; wb_en = rd_en_out;
                obs_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_flag = '0; store_flag = '0; addr_in = '0; store_data = '0;
        rd_en_in = 1'b0; rd_addr_in = '0; bus_rdata = '0; bus_ack = 1'b0;
        #1 rst = 1'b0;
        #20;
        tot_cnt++; if ({bus_req, bus_we, bus_be} !== 6'd0) $display("FAIL reset_ctrl: got %b expected 0", {bus_req, bus_we, bus_be}); else pass_cnt++;
        tot_cnt++; if ({bus_addr, bus_wdata} !== 64'd0) $display("FAIL reset_bus: got %h expected 0", {bus_addr, bus_wdata}); else pass_cnt++;
        tot_cnt++; if ({misalign, bus_err, rd_en_out, stall_req} !== 4'd0) $display("FAIL reset_flags: got %b expected 0000", {misalign, bus_err, rd_en_out, stall_req}); else pass_cnt++;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_store();
        do_access(5'd0, 3'b100, 32'h100, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'h0, 2);
        tot_cnt++; if (obs_req !== 3) $display("FAIL sw_req_cycles: got %0d expected 3", obs_req); else pass_cnt++;
        tot_cnt++; if (obs_stall !== 4) $display("FAIL sw_stall_cycles: got %0d expected 4", obs_stall); else pass_cnt++;
        tot_cnt++; if ({obs_we, obs_be, obs_addr, obs_wdata} !== {1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF}) $display("FAIL sw_bus: got %b %h %h %h expected 1 f 00000100 deadbeef", obs_we, obs_be, obs_addr, obs_wdata); else pass_cnt++;
        tot_cnt++; if (obs_rden !== 0) $display("FAIL sw_rd_en: got %0d expected 0", obs_rden); else pass_cnt++;
        do_access(5'd0, 3'b010, 32'h12, 32'h0000_ABCD, 1'b0, 5'd0, 32'h0, 0);
        tot_cnt++; if ({obs_be, obs_wdata, obs_addr} !== {4'b1100, 32'hABCD_ABCD, 32'h10}) $display("FAIL sh_bus: got %b %h %h expected 1100 abcdabcd 00000010", obs_be, obs_wdata, obs_addr); else pass_cnt++;
    endtask

    task automatic test_load_ext();
        do_access(5'b00001, 3'd0, 32'h203, 32'h0, 1'b1, 5'd9, 32'h80FF_FF00, 1);
        tot_cnt++; if ({wb_en, wb_out, wb_addr} !== {1'b1, 32'hFFFF_FF80, 5'd9}) $display("FAIL lb_wb: got %b %h %0d expected 1 ffffff80 9", wb_en, wb_out, wb_addr); else pass_cnt++;
        tot_cnt++; if (obs_rden !== 1) $display("FAIL lb_rd_en_cycles: got %0d expected 1", obs_rden); else pass_cnt++;
        do_access(5'b01000, 3'd0, 32'h203, 32'h0, 1'b1, 5'd9, 32'h80FF_FF00, 0);
        tot_cnt++; if ({wb_en, wb_out} !== {1'b1, 32'h0000_0080}) $display("FAIL lbu_wb: got %b %h expected 1 00000080", wb_en, wb_out); else pass_cnt++;
    endtask

    task automatic test_misalign();
        do_access(5'b00100, 3'd0, 32'h101, 32'h0, 1'b1, 5'd4, 32'h0, 0);
        tot_cnt++; if (obs_mis !== 1) $display("FAIL lw_misalign_pulse: got %0d expected 1", obs_mis); else pass_cnt++;
        tot_cnt++; if ({obs_req, obs_stall, obs_rden} !== {32'd0, 32'd0, 32'd0}) $display("FAIL lw_misalign_quiet: got req %0d stall %0d rd_en %0d expected 0 0 0", obs_req, obs_stall, obs_rden); else pass_cnt++;
    endtask

    task automatic test_passthru();
        do_access(5'd0, 3'd0, 32'h55, 32'h0, 1'b1, 5'd7, 32'h0, 0);
        tot_cnt++; if ({wb_en, wb_out, wb_addr, obs_stall} !== {1'b1, 32'h55, 5'd7, 32'd0}) $display("FAIL add_passthru: got %b %h %0d stall %0d expected 1 00000055 7 0", wb_en, wb_out, wb_addr, obs_stall); else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_access(5'b00100, 3'd0, 32'h40, 32'h0, 1'b1, 5'd2, 32'h1234_5678, -1);
        tot_cnt++; if ({obs_req, obs_err, obs_rden} !== {32'd4, 32'd1, 32'd0}) $display("FAIL timeout_abort: got req %0d err %0d rd_en %0d expected 4 1 0", obs_req, obs_err, obs_rden); else pass_cnt++;
        do_access(5'b00100, 3'd0, 32'h44, 32'h0, 1'b1, 5'd2, 32'h1234_5678, int'(TO) - 1);
        tot_cnt++; if ({obs_req, obs_err, wb_en, wb_out} !== {32'd4, 32'd0, 1'b1, 32'h1234_5678}) $display("FAIL ack_at_limit: got req %0d err %0d en %b data %h expected 4 0 1 12345678", obs_req, obs_err, wb_en, wb_out); else pass_cnt++;
        do_access(5'd0, 3'd0, 32'hA5, 32'h0, 1'b1, 5'd1, 32'h0, 0);
        tot_cnt++; if ({wb_en, obs_stall, obs_done} !== {1'b1, 32'd0, 1'b1}) $display("FAIL idle_after_abort: got en %b stall %0d done %b expected 1 0 1", wb_en, obs_stall, obs_done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, rd;
        for (int i = 0; i < 6; i++) begin
            a  = {$urandom_range(0, 255), 2'b00};
            rd = $urandom;
            model((i % 2) ? 5'b00100 : 5'd0, (i % 2) ? 3'd0 : 3'b100, a, rd, 1'b1, rd, 0);
            do_access((i % 2) ? 5'b00100 : 5'd0, (i % 2) ? 3'd0 : 3'b100, a, rd, 1'b1, 5'(i), rd, 0);
            tot_cnt++; if ({obs_req, obs_stall} !== {32'd1, 32'd2}) $display("FAIL b2b_latency[%0d]: got req %0d stall %0d expected 1 2", i, obs_req, obs_stall); else pass_cnt++;
            tot_cnt++; if (wb_en !== exp_wb_en || (exp_wb_en && wb_out !== exp_wb_out)) $display("FAIL b2b_wb[%0d]: got %b %h expected %b %h", i, wb_en, wb_out, exp_wb_en, exp_wb_out); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [4:0]  lf;
        logic [2:0]  sf;
        logic [31:0] a, sd, rd;
        logic        re;
        logic [4:0]  ra;
        int          w, cat;
        for (int i = 0; i < 60; i++) begin
            cat = $urandom_range(0, 3);
            lf  = (cat == 1 || cat == 3) ? 5'($urandom_range(1, 31)) : 5'd0;
            sf  = (cat == 2 || cat == 3) ? 3'($urandom_range(1, 7)) : 3'd0;
            a   = $urandom; sd = $urandom; rd = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            re  = 1'($urandom_range(0, 3) != 0);
            ra  = 5'($urandom);
            w   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4);
            model(lf, sf, a, sd, re, rd, w);
            do_access(lf, sf, a, sd, re, ra, rd, w);
            tot_cnt++; if (obs_done !== 1'b1) $display("FAIL rnd_done[%0d]: got %b expected 1 (cycle budget)", i, obs_done); else pass_cnt++;
            tot_cnt++; if ({obs_req, obs_stall, obs_mis, obs_err, obs_rden} !== {exp_req, exp_stall, exp_mis, exp_err, exp_rden})
                $display("FAIL rnd_counts[%0d]: got req %0d stall %0d mis %0d err %0d rden %0d expected %0d %0d %0d %0d %0d", i,
                         obs_req, obs_stall, obs_mis, obs_err, obs_rden, exp_req, exp_stall, exp_mis, exp_err, exp_rden);
            else pass_cnt++;
            if (exp_access) begin
                tot_cnt++; if ({obs_we, obs_addr, obs_stable} !== {exp_we, exp_addr, 1'b1}) $display("FAIL rnd_bus[%0d]: got we %b addr %h stable %b expected %b %h 1", i, obs_we, obs_addr, obs_stable, exp_we, exp_addr); else pass_cnt++;
            end
            if (exp_store) begin
                tot_cnt++; if ({obs_be, obs_wdata} !== {exp_be, exp_wdata}) $display("FAIL rnd_store_fmt[%0d]: got %b %h expected %b %h", i, obs_be, obs_wdata, exp_be, exp_wdata); else pass_cnt++;
            end
            tot_cnt++; if (wb_en !== exp_wb_en) $display("FAIL rnd_wb_en[%0d]: got %b expected %b", i, wb_en, exp_wb_en); else pass_cnt++;
            if (exp_wb_en) begin
                tot_cnt++; if ({wb_out, wb_addr} !== {exp_wb_out, ra}) $display("FAIL rnd_wb_data[%0d]: got %h %0d expected %h %0d", i, wb_out, wb_addr, exp_wb_out, ra); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        load_flag = 5'b00100; store_flag = 3'd0; addr_in = 32'h80; rd_en_in = 1'b1; rd_addr_in = 5'd5;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        tot_cnt++; if (bus_req !== 1'b1) $display("FAIL midreq_enter: got %b expected 1", bus_req); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        tot_cnt++; if ({bus_req, rd_en_out} !== 2'b00) $display("FAIL midreq_reset: got req %b rd_en %b expected 0 0", bus_req, rd_en_out); else pass_cnt++;
        load_flag = '0; rd_en_in = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_ext();
        test_misalign();
        test_passthru();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
